// File: rtl/usb_phy_pkg.sv
// Shared constants and types for the full-speed USB receive front end.
// Line-state encodings, receive FSM states and the DPLL sample bundle.
package usb_phy_pkg;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  localparam int STUFF_LIMIT  = 6;
  localparam int SYNC_TIMEOUT = 10;
  localparam int ABORT_IDLE_J = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP,
    ST_ABORT
  } rx_state_t;

  typedef struct packed {
    logic       strobe;
    logic [1:0] ls;
  } sample_t;

  function automatic logic nrzi_bit(
    input logic [1:0] cur,
    input logic [1:0] prev
  );
    return cur == prev;
  endfunction

endpackage

// File: rtl/usb_rx_dpll.sv
// Pad synchronizers, D+ edge detect and phase counter that yields
// one sample strobe per bit together with the sampled line state.
module usb_rx_dpll
  import usb_phy_pkg::*;
#(
  parameter int CLK_PER_BIT = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic       usb_p_i,
  input  logic       usb_n_i,
  output logic [1:0] line_state,
  output sample_t    sample
);

  localparam int PW = $clog2(CLK_PER_BIT);

  logic [SYNC_STAGES-1:0] p_sync;
  logic [SYNC_STAGES-1:0] n_sync;
  logic [1:0]             prev_ls;
  logic [PW-1:0]          phase;
  logic                   edge_p;

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      p_sync <= '1;
      n_sync <= '0;
    end else begin
      p_sync <= {p_sync[SYNC_STAGES-2:0], usb_p_i};
      n_sync <= {n_sync[SYNC_STAGES-2:0], usb_n_i};
    end
  end

  assign line_state = {p_sync[SYNC_STAGES-1],
                       n_sync[SYNC_STAGES-1]};
  assign edge_p = line_state[1] ^ prev_ls[1];

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      prev_ls <= LS_J;
      phase   <= '0;
    end else begin
      prev_ls <= line_state;
      if (edge_p) phase <= '0;
      else        phase <= phase + 1'b1;
    end
  end

  // Sampling the one-cycle-old state keeps 3-clock bits centred.
  always_comb begin
    sample.strobe = (phase == PW'(2));
    sample.ls     = prev_ls;
  end

endmodule

// File: rtl/usb_fs_rx_phy.sv
// Full-speed USB receive PHY: NRZI decode, SYNC detect, bit unstuffing,
// EOP detect and byte assembly on top of the oversampling DPLL.
module usb_fs_rx_phy
  import usb_phy_pkg::*;
#(
  parameter int CLK_PER_BIT = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic       usb_p_i,
  input  logic       usb_n_i,
  input  logic       rx_en,
  output logic [1:0] line_state,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error
);

  sample_t   smp;
  rx_state_t state;
  logic [1:0] last_jk;
  logic [2:0] ones;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [3:0] sync_cnt;
  logic [3:0] j_cnt;
  logic       seen_se0;

  logic       is_j, is_k, is_se0, is_se1, is_jk;
  logic       dbit;
  logic       at_stuff;
  logic [7:0] nxt_byte;

  usb_rx_dpll #(
    .CLK_PER_BIT(CLK_PER_BIT),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_dpll (
    .clk48     (clk48),
    .rst_n     (rst_n),
    .usb_p_i   (usb_p_i),
    .usb_n_i   (usb_n_i),
    .line_state(line_state),
    .sample    (smp)
  );

  assign is_j     = (smp.ls == LS_J);
  assign is_k     = (smp.ls == LS_K);
  assign is_se0   = (smp.ls == LS_SE0);
  assign is_se1   = (smp.ls == LS_SE1);
  assign is_jk    = is_j | is_k;
  assign dbit     = nrzi_bit(smp.ls, last_jk);
  assign at_stuff = (ones == 3'(STUFF_LIMIT));
  assign nxt_byte = {dbit, shreg[7:1]};

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      last_jk   <= LS_J;
      ones      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      sync_cnt  <= '0;
      j_cnt     <= '0;
      seen_se0  <= 1'b0;
      rx_active <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      if (smp.strobe && is_jk) last_jk <= smp.ls;
      if (!rx_en) begin
        state     <= ST_IDLE;
        rx_active <= 1'b0;
      end else if (smp.strobe) begin
        unique case (state)
          ST_IDLE: begin
            if (is_k) begin
              state    <= ST_SYNC;
              ones     <= '0;
              bit_cnt  <= '0;
              sync_cnt <= '0;
            end
          end
          ST_SYNC: begin
            if (is_k && last_jk == LS_K) begin
              state     <= ST_DATA;
              rx_active <= 1'b1;
            end else if (is_se0 ||
                         sync_cnt == 4'(SYNC_TIMEOUT - 1)) begin
              state <= ST_IDLE;
            end else begin
              sync_cnt <= sync_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            unique case (1'b1)
              is_se0: state <= ST_EOP;
              is_se1: begin
                rx_error <= 1'b1;
                state    <= ST_ABORT;
                seen_se0 <= 1'b0;
                j_cnt    <= '0;
              end
              is_jk && at_stuff: begin
                ones <= '0;
                if (dbit) begin
                  rx_error <= 1'b1;
                  state    <= ST_ABORT;
                  seen_se0 <= 1'b0;
                  j_cnt    <= '0;
                end
              end
              is_jk && !at_stuff: begin
                ones    <= dbit ? ones + 1'b1 : '0;
                shreg   <= nxt_byte;
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == 3'd7) begin
                  rx_data  <= nxt_byte;
                  rx_valid <= 1'b1;
                end
              end
            endcase
          end
          ST_EOP: begin
            if (is_jk) begin
              state     <= ST_IDLE;
              rx_active <= 1'b0;
            end
          end
          ST_ABORT: begin
            unique case (1'b1)
              is_se0: begin
                seen_se0 <= 1'b1;
                j_cnt    <= '0;
              end
              is_j: begin
                if (seen_se0 ||
                    j_cnt == 4'(ABORT_IDLE_J - 1)) begin
                  state     <= ST_IDLE;
                  rx_active <= 1'b0;
                end else begin
                  j_cnt <= j_cnt + 1'b1;
                end
              end
              default: j_cnt <= '0;
            endcase
          end
          default: begin
            state     <= ST_IDLE;
            rx_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/usb_fs_rx_phy.md
Name: usb_fs_rx_phy

Overview:
- Full-speed (12 Mb/s) USB receive front end, directly upstream of the usb2uart USB core.
- Oversamples the D+/D- pads at 48 MHz and recovers bit timing with a small DPLL.
- Performs NRZI decode, SYNC detect, bit unstuffing and EOP detect.
- Delivers received packet bytes with a valid strobe plus packet-active and error flags.

Parameters:
- CLK_PER_BIT, 4, clk48 cycles per USB bit; only 4 is supported, used for phase counter width.
- SYNC_STAGES, 2, input synchronizer depth per pad (≥2).

Ports:
- clk48  input  1  48 MHz clock, single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- usb_p_i  input  1  raw D+ pad input.
- usb_n_i  input  1  raw D- pad input.
- rx_en  input  1  receive enable; the core drives it low while transmitting (~usb_tx_en).
- line_state  output  2  synchronized {D+,D-}: J=2'b10, K=2'b01, SE0=2'b00, SE1=2'b11.
- rx_active  output  1  high from SYNC detected until EOP completed.
- rx_data  output  8  last assembled byte, LSB received first.
- rx_valid  output  1  one-cycle strobe; rx_data is valid in the same cycle.
- rx_error  output  1  one-cycle strobe on stuff violation or SE1 in packet.

Behaviour:
- Reset (async, rst_n=0):
  - Synchronizers load J (2'b10).
  - line_state=2'b10; rx_active, rx_valid, rx_error=0; rx_data=8'h00.
  - FSM=IDLE; DPLL phase=0.
- Synchronizer: SYNC_STAGES flops per pad; line_state is the last stage.
- DPLL:
  - 2-bit phase counter, free-running mod 4.
  - A transition of synchronized D+ (vs. previous cycle) reloads phase to 0.
  - Sample strobe fires when phase==2, i.e. 3 clocks after the edge cycle, then every 4 clocks with no edge.
  - Tolerates bit periods of 3..5 clocks.
- NRZI decode, on each sample strobe: bit=1 if the sampled line state equals the previous sample, else 0. SE0/SE1 samples are handled by the FSM, not decoded.
- FSM states are IDLE, SYNC, DATA, EOP, ABORT.
- IDLE:
  - rx_active=0.
  - First K sample → SYNC; clear the ones-counter and bit count.
- SYNC:
  - Two consecutive K samples (the final "KK" of KJKJKJKK) → DATA; rx_active=1 on the next clock.
  - SE0 sample, or 10 samples without KK → IDLE.
- DATA:
  - Ones-counter increments on each decoded 1 and clears on 0.
  - When the counter reaches 6, the next bit is a stuff bit:
    - decoded 0 → discard and clear the counter;
    - decoded 1 → rx_error pulse, go to ABORT.
  - Non-stuff bits shift into an 8-bit register LSB first.
  - On the 8th bit: rx_data<=byte and rx_valid=1 for exactly one cycle, registered the clock after the sample strobe. Bit count wraps to 0.
  - SE0 sample → EOP; any partial byte (1..7 bits) is discarded silently.
  - SE1 sample → rx_error pulse, ABORT.
- EOP:
  - J sample → IDLE; rx_active falls on the next clock.
  - K sample → IDLE; rx_active falls, no error.
- ABORT:
  - rx_active stays 1; no rx_valid.
  - Wait for SE0 then J, or 16 consecutive J samples → IDLE.
- rx_en=0 in any state:
  - FSM→IDLE on the next clock; rx_active=0.
  - No rx_valid or rx_error generated.
  - The synchronizer and line_state keep running.
- Simultaneous 8th bit and stuff violation cannot occur; a stuff bit is never counted as data.
- rx_valid and rx_error are never asserted together.
- rx_data holds its value between strobes.

Decomposition:
- Package usb_phy_pkg:
  - line-state constants LS_J, LS_K, LS_SE0, LS_SE1;
  - rx FSM state enum;
  - STUFF_LIMIT=6;
  - SYNC_TIMEOUT=10;
  - ABORT_IDLE_J=16.
- Sub-module usb_rx_dpll (synchronizer + edge detect + phase counter → sample strobe, sampled line state).
- The FSM, NRZI decode and unstuff/shift logic stay in usb_fs_rx_phy.

Test Plan:
- Reset asserted mid-packet → all outputs reset immediately (async); line_state=2'b10; no rx_valid after release until a new SYNC.
- SYNC + 0xA5 + SE0,SE0,J at exactly 4 clk/bit:
  - rx_active rises after the KK;
  - one rx_valid with rx_data=8'hA5;
  - rx_active falls one clock after the J sample.
- SYNC + 0xFF,0x00 with a stuffed 0 inserted after six 1s → two rx_valid strobes, 8'hFF then 8'h00; rx_error never asserted.
- SYNC + seven consecutive decoded 1s:
  - one rx_error pulse;
  - no rx_valid afterwards;
  - rx_active stays high until SE0,J and then falls.
- SYNC + 0xC3,0x3C with bit periods alternating 3 and 5 clocks → rx_data 8'hC3 then 8'h3C; no errors.
- rx_en driven low after the 4th bit of 0x5A → rx_active=0 next clock; no rx_valid; a later packet with rx_en=1 is received correctly.
